// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: radix-2 restoring divide sequencer beside the EX stage. It produces one quotient bit
// per clock and holds stall_req while busy. Signed DIV support is enabled by defining EX_DIV_SIGNED_EN.
module ex_div_ctrl #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              signed_op,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   input  logic              cancel,
   output logic              stall_req,
   output logic              result_valid,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DZERO, S_DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_dvd;
   logic [DATA_W-1:0] r_dvs;
   logic [DATA_W-1:0] r_raw_dvd;
   logic [DATA_W-1:0] r_quo;
   logic [DATA_W-1:0] r_rmd;
   logic              r_valid;

   logic              w_accept;
   logic              w_last;
   logic              w_q_bit;
   logic [DATA_W:0]   w_rem_sh;
   logic [DATA_W:0]   w_trial;
   logic [DATA_W:0]   w_rem_mux;
   logic [DATA_W-1:0] w_rem_next;
   logic [DATA_W-1:0] w_dvd_next;
   logic [DATA_W-1:0] w_abs_dvd;
   logic [DATA_W-1:0] w_abs_dvs;
   logic [DATA_W-1:0] w_quo_fix;
   logic [DATA_W-1:0] w_rem_fix;

   assign w_accept = start & ~cancel;
   assign w_last   = (r_cnt == LAST_CNT);

   // Shifted remainder is one bit wider so its MSB survives the trial compare.
   // The kept remainder is always below the divisor, so its top bit is zero.
   assign w_rem_sh   = {r_rem, r_dvd[DATA_W-1]};
   assign w_trial    = w_rem_sh - {1'b0, r_dvs};
   assign w_q_bit    = (w_rem_sh >= {1'b0, r_dvs});
   assign w_rem_mux  = w_q_bit ? w_trial : w_rem_sh;
   assign w_rem_next = w_rem_mux[DATA_W-1:0];
   assign w_dvd_next = {r_dvd[DATA_W-2:0], w_q_bit};

`ifdef EX_DIV_SIGNED_EN
   logic w_neg_dvd;
   logic w_neg_dvs;
   logic r_neg_q;
   logic r_neg_r;
   logic w_unused_msb;

   assign w_neg_dvd    = signed_op & dividend[DATA_W-1];
   assign w_neg_dvs    = signed_op & divisor[DATA_W-1];
   assign w_abs_dvd    = w_neg_dvd ? (~dividend + 1'b1) : dividend;
   assign w_abs_dvs    = w_neg_dvs ? (~divisor + 1'b1) : divisor;
   assign w_quo_fix    = r_neg_q ? (~w_dvd_next + 1'b1) : w_dvd_next;
   assign w_rem_fix    = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
   assign w_unused_msb = w_rem_mux[DATA_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (r_state == S_IDLE && w_accept) begin
         r_neg_q <= w_neg_dvd ^ w_neg_dvs;
         r_neg_r <= w_neg_dvd;
      end
   end
`else
   logic [1:0] w_unused_sig;

   assign w_abs_dvd    = dividend;
   assign w_abs_dvs    = divisor;
   assign w_quo_fix    = w_dvd_next;
   assign w_rem_fix    = w_rem_next;
   assign w_unused_sig = {signed_op, w_rem_mux[DATA_W]};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      stall_req    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               stall_req    = 1'b1;
               w_state_next = (divisor == '0) ? S_DZERO : S_BUSY;
            end
         end
         S_BUSY: begin
            stall_req = 1'b1;
            if (cancel) begin
               w_state_next = S_IDLE;
            end else if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DZERO: begin
            stall_req    = 1'b1;
            w_state_next = cancel ? S_IDLE : S_DONE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Result registers load on the edge entering DONE, so the valid pulse and data coincide.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_rem     <= '0;
         r_dvd     <= '0;
         r_dvs     <= '0;
         r_raw_dvd <= '0;
         r_quo     <= '0;
         r_rmd     <= '0;
         r_valid   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_rem     <= '0;
                  r_dvd     <= w_abs_dvd;
                  r_dvs     <= w_abs_dvs;
                  r_raw_dvd <= dividend;
                  r_cnt     <= '0;
               end
            end
            S_BUSY: begin
               if (!cancel) begin
                  r_rem <= w_rem_next;
                  r_dvd <= w_dvd_next;
                  r_cnt <= r_cnt + 1'b1;
                  if (w_last) begin
                     r_quo   <= w_quo_fix;
                     r_rmd   <= w_rem_fix;
                     r_valid <= 1'b1;
                  end
               end
            end
            S_DZERO: begin
               if (!cancel) begin
                  r_quo   <= '1;
                  r_rmd   <= r_raw_dvd;
                  r_valid <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign result_valid = r_valid;
   assign quotient     = r_quo;
   assign remainder    = r_rmd;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb_ex_div_ctrl: scoreboard bench for ex_div_ctrl. Expected {quotient, remainder} pairs are queued
// when an operation is issued and popped when its result_valid pulse is observed.
module tb_ex_div_ctrl;
   localparam int MAX_CYC = 80;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        signed_op;
   logic        cancel;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        stall_req;
   logic        result_valid;
   logic [31:0] quotient;
   logic [31:0] remainder;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] sb_q[$];
   logic [31:0] last_q;
   logic [31:0] last_r;

   ex_div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .signed_op   (signed_op),
      .dividend    (dividend),
      .divisor     (divisor),
      .cancel      (cancel),
      .stall_req   (stall_req),
      .result_valid(result_valid),
      .quotient    (quotient),
      .remainder   (remainder)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic [31:0] q;
      logic [31:0] r;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else begin
         q = a / b;
         r = a % b;
`ifdef EX_DIV_SIGNED_EN
         if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               q = 32'h8000_0000;
               r = 32'd0;
            end else begin
               q = $signed(a) / $signed(b);
               r = $signed(a) % $signed(b);
            end
         end
`else
         begin
            logic unused_s;
            unused_s = s;
         end
`endif
      end
      return {q, r};
   endfunction

   // Issues one operation in cycle 0, holds start while stalled, optionally cancels in cycle
   // cancel_at, and returns what was observed until stall_req drops.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int cancel_at, output int valid_cycle, output int n_valid,
                         output int n_stall, output int stall_last, output logic [31:0] obs_q,
                         output logic [31:0] obs_r, output logic timed_out);
      logic hold;
      valid_cycle = -1;
      n_valid     = 0;
      n_stall     = 0;
      stall_last  = -1;
      obs_q       = 'x;
      obs_r       = 'x;
      timed_out   = 1'b1;
      hold        = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b1;
      signed_op = s;
      dividend  = a;
      divisor   = b;
      cancel    = (cancel_at == 0);
      for (int k = 0; k < MAX_CYC; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
            cancel = (k == cancel_at);
            if (!hold || (cancel_at >= 0 && k >= cancel_at)) start = 1'b0;
         end
         @(negedge clk);
         if (stall_req) begin
            n_stall++;
            stall_last = k;
         end
         if (result_valid) begin
            n_valid++;
            valid_cycle = k;
            obs_q = quotient;
            obs_r = remainder;
         end
         hold = stall_req;
         if (k > 0 && !stall_req) begin
            timed_out = 1'b0;
            break;
         end
      end
      start  = 1'b0;
      cancel = 1'b0;
      $display("op %h / %h s=%0d cancel_at=%0d -> valid_cycle=%0d q=%h r=%h stall_cycles=%0d",
               a, b, s, cancel_at, valid_cycle, obs_q, obs_r, n_stall);
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      start     = 1'b0;
      cancel    = 1'b0;
      signed_op = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_req); end
      checks++;
      if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", result_valid); end
      checks++;
      if (quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient got %h want 0", quotient); end
      checks++;
      if (remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder got %h want 0", remainder); end
      last_q = 32'd0;
      last_r = 32'd0;
   endtask

   task automatic test_divu_basic();
      int vc, nv, ns, sl;
      logic [31:0] oq, orm;
      logic to;
      logic [63:0] exp;
      sb_q.push_back({32'd14, 32'd2});
      run_op(32'd100, 32'd7, 1'b0, -1, vc, nv, ns, sl, oq, orm, to);
      exp = sb_q.pop_front();
      checks++;
      if (to) begin errors++; $display("FAIL divu_timeout got no completion want completion"); end
      checks++;
      if (vc !== 33 || nv !== 1) begin errors++; $display("FAIL divu_latency got cycle %0d pulses %0d want 33/1", vc, nv); end
      checks++;
      if (ns !== 33 || sl !== 32) begin errors++; $display("FAIL divu_stall got %0d cycles last %0d want 33/32", ns, sl); end
      checks++;
      if (oq !== exp[63:32]) begin errors++; $display("FAIL divu_quotient got %h want %h", oq, exp[63:32]); end
      checks++;
      if (orm !== exp[31:0]) begin errors++; $display("FAIL divu_remainder got %h want %h", orm, exp[31:0]); end
      last_q = exp[63:32];
      last_r = exp[31:0];
   endtask

   task automatic test_divu_max();
      int vc, nv, ns, sl;
      logic [31:0] oq, orm;
      logic to;
      logic [63:0] exp;
      sb_q.push_back({32'hFFFF_FFFF, 32'd0});
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, -1, vc, nv, ns, sl, oq, orm, to);
      exp = sb_q.pop_front();
      checks++;
      if (to || vc !== 33 || nv !== 1) begin errors++; $display("FAIL max_latency got cycle %0d pulses %0d want 33/1", vc, nv); end
      checks++;
      if (oq !== exp[63:32]) begin errors++; $display("FAIL max_quotient got %h want %h", oq, exp[63:32]); end
      checks++;
      if (orm !== exp[31:0]) begin errors++; $display("FAIL max_remainder got %h want %h", orm, exp[31:0]); end
      last_q = exp[63:32];
      last_r = exp[31:0];
   endtask

   task automatic test_div_zero();
      int vc, nv, ns, sl;
      logic [31:0] oq, orm;
      logic to;
      logic [63:0] exp;
      sb_q.push_back({32'hFFFF_FFFF, 32'h0000_1234});
      run_op(32'h0000_1234, 32'd0, 1'b0, -1, vc, nv, ns, sl, oq, orm, to);
      exp = sb_q.pop_front();
      checks++;
      if (to || vc !== 2 || nv !== 1) begin errors++; $display("FAIL dzero_latency got cycle %0d pulses %0d want 2/1", vc, nv); end
      checks++;
      if (ns !== 2 || sl !== 1) begin errors++; $display("FAIL dzero_stall got %0d cycles last %0d want 2/1", ns, sl); end
      checks++;
      if (oq !== exp[63:32]) begin errors++; $display("FAIL dzero_quotient got %h want %h", oq, exp[63:32]); end
      checks++;
      if (orm !== exp[31:0]) begin errors++; $display("FAIL dzero_remainder got %h want %h", orm, exp[31:0]); end
      last_q = exp[63:32];
      last_r = exp[31:0];
   endtask

   task automatic test_cancel();
      int vc, nv, ns, sl;
      logic [31:0] oq, orm;
      logic to;
      logic [63:0] exp;
      int cancel_tab[3] = '{10, 0, 32};
      foreach (cancel_tab[i]) begin
         run_op(32'd100, 32'd7, 1'b0, cancel_tab[i], vc, nv, ns, sl, oq, orm, to);
         checks++;
         if (to || nv !== 0) begin errors++; $display("FAIL cancel%0d_novalid got pulses %0d want 0", cancel_tab[i], nv); end
         checks++;
         if (ns !== cancel_tab[i] + (cancel_tab[i] > 0 ? 1 : 0) || stall_req !== 1'b0) begin
            errors++;
            $display("FAIL cancel%0d_stall got %0d stall cycles want %0d", cancel_tab[i], ns, cancel_tab[i] + 1);
         end
         checks++;
         if (quotient !== last_q || remainder !== last_r) begin
            errors++;
            $display("FAIL cancel%0d_hold got %h/%h want %h/%h", cancel_tab[i], quotient, remainder, last_q, last_r);
         end
         if (i == 0) begin
            sb_q.push_back({32'd14, 32'd2});
            run_op(32'd100, 32'd7, 1'b0, -1, vc, nv, ns, sl, oq, orm, to);
            exp = sb_q.pop_front();
            checks++;
            if (to || vc !== 33 || nv !== 1) begin errors++; $display("FAIL restart_latency got cycle %0d pulses %0d want 33/1", vc, nv); end
            checks++;
            if (oq !== exp[63:32] || orm !== exp[31:0]) begin
               errors++;
               $display("FAIL restart_result got %h/%h want %h/%h", oq, orm, exp[63:32], exp[31:0]);
            end
            last_q = exp[63:32];
            last_r = exp[31:0];
         end
      end
   endtask

   task automatic test_signed();
      int vc, nv, ns, sl;
      logic [31:0] oq, orm;
      logic to;
      logic [63:0] exp;
      logic [31:0] a_tab[6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
      logic [31:0] b_tab[6] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0};
      logic        s_tab[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      foreach (a_tab[i]) begin
         if (i == 0) begin
`ifdef EX_DIV_SIGNED_EN
            sb_q.push_back({32'hFFFF_FFFD, 32'hFFFF_FFFF});
`else
            sb_q.push_back({32'h7FFF_FFFC, 32'd1});
`endif
         end else if (i == 1) begin
            sb_q.push_back({32'h7FFF_FFFC, 32'd1});
         end else begin
            sb_q.push_back(model(a_tab[i], b_tab[i], s_tab[i]));
         end
         run_op(a_tab[i], b_tab[i], s_tab[i], -1, vc, nv, ns, sl, oq, orm, to);
         exp = sb_q.pop_front();
         checks++;
         if (to || nv !== 1 || vc !== (b_tab[i] == 0 ? 2 : 33)) begin
            errors++;
            $display("FAIL signed%0d_latency got cycle %0d pulses %0d", i, vc, nv);
         end
         checks++;
         if (oq !== exp[63:32] || orm !== exp[31:0]) begin
            errors++;
            $display("FAIL signed%0d_result got %h/%h want %h/%h", i, oq, orm, exp[63:32], exp[31:0]);
         end
         last_q = exp[63:32];
         last_r = exp[31:0];
      end
   endtask

   task automatic test_back_to_back();
      int vc, nv, ns, sl;
      logic [31:0] oq, orm;
      logic to;
      logic [63:0] exp;
      logic [31:0] a, b;
      logic s;
      for (int i = 0; i < 8; i++) begin
         a = $urandom;
         b = (i == 3) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 255)) : $urandom);
         s = 1'($urandom_range(0, 1));
         sb_q.push_back(model(a, b, s));
         run_op(a, b, s, -1, vc, nv, ns, sl, oq, orm, to);
         exp = sb_q.pop_front();
         checks++;
         if (to || nv !== 1 || vc !== (b == 0 ? 2 : 33)) begin
            errors++;
            $display("FAIL b2b%0d_latency got cycle %0d pulses %0d", i, vc, nv);
         end
         checks++;
         if (oq !== exp[63:32] || orm !== exp[31:0]) begin
            errors++;
            $display("FAIL b2b%0d_result got %h/%h want %h/%h", i, oq, orm, exp[63:32], exp[31:0]);
         end
         last_q = exp[63:32];
         last_r = exp[31:0];
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      seen = 0;
      @(posedge clk);
      #1;
      start     = 1'b1;
      signed_op = 1'b0;
      dividend  = 32'd1000;
      divisor   = 32'd3;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      rst   = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (stall_req !== 1'b0 || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_ctrl got stall %b valid %b want 0/0", stall_req, result_valid);
      end
      checks++;
      if (quotient !== 32'd0 || remainder !== 32'd0) begin
         errors++;
         $display("FAIL midrst_outputs got %h/%h want 0/0", quotient, remainder);
      end
      repeat (40) begin
         @(negedge clk);
         if (result_valid) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL midrst_novalid got %0d pulses want 0", seen); end
      $display("mid-operation reset: outputs %h/%h, later pulses %0d", quotient, remainder, seen);
   endtask

   initial begin
      test_reset();
      test_divu_basic();
      test_divu_max();
      test_div_zero();
      test_cancel();
      test_signed();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no completion want finish before 500000");
      $fatal(1, "watchdog expired");
   end

endmodule
